fb_scanout: RTL and testbench



---
 rtl/fb_video_pkg.sv | 64 ++++++
 rtl/video_timing_gen.sv | 66 ++++++
 rtl/fb_scanout.sv | 187 ++++++++++++++++++
 tb/tb_fb_scanout.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_video_pkg.sv
//----------------------------------------------------------------------------
// Module   : fb_video_pkg
// Brief    : 640x480@60 timing constants, framebuffer geometry, colour bars
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package fb_video_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam int FB_W     = 320;
   localparam int FB_H     = 240;
   localparam int FB_DEPTH = FB_W * FB_H;

   localparam int NUM_BARS = 8;

   typedef logic [23:0] rgb_t;

   localparam rgb_t BAR_WHITE   = 24'hFF_FF_FF;
   localparam rgb_t BAR_YELLOW  = 24'hFF_FF_00;
   localparam rgb_t BAR_CYAN    = 24'h00_FF_FF;
   localparam rgb_t BAR_GREEN   = 24'h00_FF_00;
   localparam rgb_t BAR_MAGENTA = 24'hFF_00_FF;
   localparam rgb_t BAR_RED     = 24'hFF_00_00;
   localparam rgb_t BAR_BLUE    = 24'h00_00_FF;
   localparam rgb_t BAR_BLACK   = 24'h00_00_00;

   // Per-pixel timing flags carried alongside the framebuffer read
   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
      logic origin;
   } vid_flags_t;

   function automatic rgb_t bar_colour(input logic [2:0] idx);
      rgb_t c;
      case (idx)
         3'd0:    c = BAR_WHITE;
         3'd1:    c = BAR_YELLOW;
         3'd2:    c = BAR_CYAN;
         3'd3:    c = BAR_GREEN;
         3'd4:    c = BAR_MAGENTA;
         3'd5:    c = BAR_RED;
         3'd6:    c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/video_timing_gen.sv
//----------------------------------------------------------------------------
// Module   : video_timing_gen
// Brief    : h/v raster counters with active, sync and frame-origin decode
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module video_timing_gen
   import fb_video_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit SYNC_POL = 1'b0,
   parameter int H_CNT_W  = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
   parameter int V_CNT_W  = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [H_CNT_W-1:0] h_cnt,
   output logic [V_CNT_W-1:0] v_cnt,
   output logic               active,
   output logic               hsync,
   output logic               vsync,
   output logic               origin,
   output logic               h_wrap,
   output logic               v_wrap
);

   localparam logic [H_CNT_W-1:0] c_h_act   = H_CNT_W'(H_ACTIVE);
   localparam logic [H_CNT_W-1:0] c_hs_beg  = H_CNT_W'(H_ACTIVE + H_FP);
   localparam logic [H_CNT_W-1:0] c_hs_end  = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [H_CNT_W-1:0] c_h_last  = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [V_CNT_W-1:0] c_v_act   = V_CNT_W'(V_ACTIVE);
   localparam logic [V_CNT_W-1:0] c_vs_beg  = V_CNT_W'(V_ACTIVE + V_FP);
   localparam logic [V_CNT_W-1:0] c_vs_end  = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [V_CNT_W-1:0] c_v_last  = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_wrap) begin
         h_cnt <= '0;
         v_cnt <= v_wrap ? '0 : v_cnt + V_CNT_W'(1);
      end else begin
         h_cnt <= h_cnt + H_CNT_W'(1);
      end
   end

   // v_wrap flags the last line; the frame ends where it coincides with h_wrap
   assign h_wrap = (h_cnt == c_h_last);
   assign v_wrap = (v_cnt == c_v_last);
   assign active = (h_cnt < c_h_act) && (v_cnt < c_v_act);
   assign origin = (h_cnt == '0) && (v_cnt == '0);
   assign hsync  = ((h_cnt >= c_hs_beg) && (h_cnt < c_hs_end)) ? SYNC_POL : ~SYNC_POL;
   assign vsync  = ((v_cnt >= c_vs_beg) && (v_cnt < c_vs_end)) ? SYNC_POL : ~SYNC_POL;

endmodule

`default_nettype wire

// File: rtl/fb_scanout.sv
//----------------------------------------------------------------------------
// Module   : fb_scanout
// Brief    : 2x-upscaled framebuffer scan-out with 3-cycle aligned video out.
//            Optional colour-bar source: FB_SCANOUT_TEST_PATTERN_EN
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module fb_scanout
   import fb_video_pkg::*;
#(
   parameter int H_ACTIVE   = VGA_H_ACTIVE,
   parameter int H_FP       = VGA_H_FP,
   parameter int H_SYNC     = VGA_H_SYNC,
   parameter int H_BP       = VGA_H_BP,
   parameter int V_ACTIVE   = VGA_V_ACTIVE,
   parameter int V_FP       = VGA_V_FP,
   parameter int V_SYNC     = VGA_V_SYNC,
   parameter int V_BP       = VGA_V_BP,
   parameter bit SYNC_POL   = 1'b0,
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  fb_en_rd,
   output logic [ADDR_WIDTH-1:0] fb_addr_rd,
   input  logic [DATA_WIDTH-1:0] fb_dout,
   input  logic                  pattern_sel,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  de,
   output logic [DATA_WIDTH-1:0] rgb,
   output logic                  frame_start
);

   localparam int c_h_w = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam int c_v_w = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

   localparam logic [c_v_w-1:0]      c_v_act    = c_v_w'(V_ACTIVE);
   localparam logic [ADDR_WIDTH-1:0] c_line_inc = ADDR_WIDTH'(H_ACTIVE / 2);

   localparam vid_flags_t c_flags_idle = '{
      active: 1'b0, hsync: ~SYNC_POL, vsync: ~SYNC_POL, origin: 1'b0
   };

   logic [c_h_w-1:0]      w_h_cnt;
   logic [c_v_w-1:0]      w_v_cnt;
   logic                  w_active;
   logic                  w_hsync;
   logic                  w_vsync;
   logic                  w_origin;
   logic                  w_h_wrap;
   logic                  w_v_wrap;
   logic                  w_rd_en;
   logic [DATA_WIDTH-1:0] w_pix;
   vid_flags_t            w_flags_s0;
   vid_flags_t            r_flags_d1;
   vid_flags_t            r_flags_d2;
   logic [ADDR_WIDTH-1:0] r_line_base;

   video_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .SYNC_POL (SYNC_POL),
      .H_CNT_W  (c_h_w),
      .V_CNT_W  (c_v_w)
   ) u_timing (
      .clk    (clk),
      .rst_n  (rst_n),
      .h_cnt  (w_h_cnt),
      .v_cnt  (w_v_cnt),
      .active (w_active),
      .hsync  (w_hsync),
      .vsync  (w_vsync),
      .origin (w_origin),
      .h_wrap (w_h_wrap),
      .v_wrap (w_v_wrap)
   );

   assign w_flags_s0 = '{active: w_active, hsync: w_hsync, vsync: w_vsync, origin: w_origin};

   // Each stored row is shown on two screen lines, so the base advances
   // only after the odd line of each pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_line_base <= '0;
      end else if (w_h_wrap) begin
         if (w_v_wrap) begin
            r_line_base <= '0;
         end else if (w_v_cnt[0] && (w_v_cnt < c_v_act)) begin
            r_line_base <= r_line_base + c_line_inc;
         end
      end
   end

`ifdef FB_SCANOUT_TEST_PATTERN_EN
   localparam int c_bar_w = H_ACTIVE / NUM_BARS;

   logic             r_pat_d1;
   logic             r_pat_d2;
   logic [c_h_w-1:0] r_h_d1;
   logic [c_h_w-1:0] r_h_d2;
   logic [2:0]       w_bar_idx;

   assign w_rd_en = w_active & ~pattern_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pat_d1 <= 1'b0;
         r_pat_d2 <= 1'b0;
         r_h_d1   <= '0;
         r_h_d2   <= '0;
      end else begin
         r_pat_d1 <= pattern_sel;
         r_pat_d2 <= r_pat_d1;
         r_h_d1   <= w_h_cnt;
         r_h_d2   <= r_h_d1;
      end
   end

   always_comb begin
      w_bar_idx = '0;
      for (int i = 1; i < NUM_BARS; i++) begin
         if (r_h_d2 >= c_h_w'(i * c_bar_w)) begin
            w_bar_idx = 3'(i);
         end
      end
   end

   assign w_pix = r_pat_d2 ? DATA_WIDTH'(bar_colour(w_bar_idx)) : fb_dout;
`else
   logic unused_pattern_sel;

   assign unused_pattern_sel = pattern_sel;
   assign w_rd_en            = w_active;
   assign w_pix              = fb_dout;
`endif

   // Address holds while disabled so it never runs past the last stored pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fb_en_rd   <= 1'b0;
         fb_addr_rd <= '0;
      end else begin
         fb_en_rd <= w_rd_en;
         if (w_rd_en) begin
            fb_addr_rd <= r_line_base + ADDR_WIDTH'(w_h_cnt >> 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags_d1 <= c_flags_idle;
         r_flags_d2 <= c_flags_idle;
      end else begin
         r_flags_d1 <= w_flags_s0;
         r_flags_d2 <= r_flags_d1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         de          <= 1'b0;
         rgb         <= '0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= r_flags_d2.hsync;
         vsync       <= r_flags_d2.vsync;
         de          <= r_flags_d2.active;
         rgb         <= r_flags_d2.active ? w_pix : '0;
         frame_start <= r_flags_d2.origin;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fb_scanout.sv
//----------------------------------------------------------------------------
// Module   : tb_fb_scanout
// Brief    : Directed bench; full 800-cycle lines, short 12-line frames
// Revision : 1.0
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fb_scanout;

   localparam int V_ACTIVE = 8;
   localparam int V_FP     = 1;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 1;
   localparam int H_TOT    = 800;
   localparam int V_TOT    = 12;
   localparam int FRAME    = H_TOT * V_TOT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pattern_sel = 1'b0;
   logic        fb_en_rd;
   logic [16:0] fb_addr_rd;
   logic [23:0] fb_dout = '0;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic [23:0] rgb;
   logic        frame_start;

   int checks = 0;
   int errors = 0;

   logic [23:0] bars [8];

   always #5 clk = ~clk;

   fb_scanout #(
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fb_en_rd    (fb_en_rd),
      .fb_addr_rd  (fb_addr_rd),
      .fb_dout     (fb_dout),
      .pattern_sel (pattern_sel),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .rgb         (rgb),
      .frame_start (frame_start)
   );

   // Framebuffer model: stored pixel value equals its address, 1-cycle read
   always @(posedge clk) begin
      if (fb_en_rd) fb_dout <= 24'(fb_addr_rd);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_hsync"}, hsync, 1);
      check({tag, "_vsync"}, vsync, 1);
      check({tag, "_de"}, de, 0);
      check({tag, "_rgb"}, rgb, 0);
      check({tag, "_fs"}, frame_start, 0);
      check({tag, "_en"}, fb_en_rd, 0);
      check({tag, "_addr"}, fb_addr_rd, 0);
   endtask

   initial begin
      int k, p, h, v, pe, he, ve;
      bit exp_de, exp_hs, exp_vs, exp_fs, exp_en;
      int exp_rgb, exp_addr;
      int mm_de, mm_hs, mm_vs, mm_fs, mm_rgb, mm_en, mm_addr, mm_pat;
      int de_cnt, hs_low, vs_low, fs_cnt, max_addr;
      int fs_k0, fs_k1, hs_f0, hs_f1;
      logic prev_hs;

      bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
      bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
      mm_de = 0; mm_hs = 0; mm_vs = 0; mm_fs = 0; mm_rgb = 0; mm_en = 0; mm_addr = 0; mm_pat = 0;
      de_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0; max_addr = 0;
      fs_k0 = -1; fs_k1 = -1; hs_f0 = -1; hs_f1 = -1;

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_values("rst");

      // Release; counters sit at (0,0) during the cycle before the first edge
      rst_n = 1'b1;
      @(negedge clk); k = 1;
      check("fill1_en", fb_en_rd, 1);
      check("fill1_addr", fb_addr_rd, 0);
      check("fill1_de", de, 0);
      @(negedge clk); k = 2;
      check("fill2_de", de, 0);
      check("fill2_hsync", hsync, 1);
      prev_hs = hsync;

      // Two full frames: output after edge k belongs to raster position k-3
      for (k = 3; k <= 2 * FRAME + 2; k++) begin
         @(negedge clk);
         p  = k - 3;
         h  = p % H_TOT;
         v  = (p / H_TOT) % V_TOT;
         pe = k - 1;
         he = pe % H_TOT;
         ve = (pe / H_TOT) % V_TOT;
         exp_de   = (h < 640) && (v < V_ACTIVE);
         exp_hs   = !((h >= 656) && (h < 752));
         exp_vs   = !((v >= 9) && (v < 11));
         exp_fs   = (h == 0) && (v == 0);
         exp_rgb  = exp_de ? (v / 2) * 320 + h / 2 : 0;
         exp_en   = (he < 640) && (ve < V_ACTIVE);
         exp_addr = (ve / 2) * 320 + he / 2;

         if (de !== exp_de) mm_de++;
         if (hsync !== exp_hs) mm_hs++;
         if (vsync !== exp_vs) mm_vs++;
         if (frame_start !== exp_fs) mm_fs++;
         if (rgb !== 24'(exp_rgb)) mm_rgb++;
         if (fb_en_rd !== exp_en) mm_en++;
         if (exp_en && (fb_addr_rd !== 17'(exp_addr))) mm_addr++;

         if (de === 1'b1) de_cnt++;
         if (hsync === 1'b0) hs_low++;
         if (vsync === 1'b0) vs_low++;
         if (fb_en_rd === 1'b1 && int'(fb_addr_rd) > max_addr) max_addr = int'(fb_addr_rd);
         if (frame_start === 1'b1) begin
            fs_cnt++;
            if (fs_k0 < 0) fs_k0 = k; else if (fs_k1 < 0) fs_k1 = k;
         end
         if (prev_hs === 1'b1 && hsync === 1'b0) begin
            if (hs_f0 < 0) hs_f0 = k; else if (hs_f1 < 0) hs_f1 = k;
         end
         prev_hs = hsync;

         if (p == 0) begin
            check("px_0_0", rgb, 0);
            check("fs_0_0", frame_start, 1);
         end
         if (p == 801) check("px_1_1", rgb, 0);
         if (p == 2) check("px_2_0", rgb, 1);
         if (p == 7 * H_TOT + 639) check("px_last", rgb, 1279);
         if (p == FRAME) check("f2_px_0_0", rgb, 0);
         if (p == FRAME + 2) check("f2_px_2_0", rgb, 1);
         if (p == FRAME + 2 * H_TOT + 2) check("f2_px_2_2", rgb, 321);
      end

      check("mm_de", mm_de, 0);
      check("mm_hsync", mm_hs, 0);
      check("mm_vsync", mm_vs, 0);
      check("mm_frame_start", mm_fs, 0);
      check("mm_rgb", mm_rgb, 0);
      check("mm_en_rd", mm_en, 0);
      check("mm_addr", mm_addr, 0);
      check("de_count", de_cnt, 10240);
      check("hsync_low", hs_low, 2304);
      check("vsync_low", vs_low, 3200);
      check("hsync_period", hs_f1 - hs_f0, 800);
      check("fs_count", fs_cnt, 2);
      check("fs_period", fs_k1 - fs_k0, FRAME);
      check("max_addr", max_addr, 1279);

      // Run into frame 3 up to counters at (300,5), then reset mid-line
      while (k < 2 * FRAME + 5 * H_TOT + 300) begin
         @(negedge clk);
         k++;
      end
      check("pre_rst_de", de, 1);
      check("pre_rst_rgb", rgb, 788);
      #2 rst_n = 1'b0;
      #1 check_reset_values("async_rst");
      repeat (2) @(negedge clk);
      check_reset_values("held_rst");
      rst_n = 1'b1;
      @(negedge clk); k = 1;
      check("rr1_en", fb_en_rd, 1);
      check("rr1_addr", fb_addr_rd, 0);
      check("rr1_de", de, 0);
      @(negedge clk); k = 2;
      check("rr2_de", de, 0);
      @(negedge clk); k = 3;
      check("rr3_de", de, 1);
      check("rr3_fs", frame_start, 1);
      check("rr3_rgb", rgb, 0);
      @(negedge clk); k = 4;
      @(negedge clk); k = 5;
      check("rr5_rgb", rgb, 1);

      // pattern_sel: colour bars when built in, otherwise ignored
      pattern_sel = 1'b1;
      for (k = 6; k <= 1605; k++) begin
         @(negedge clk);
         p  = k - 3;
         h  = p % H_TOT;
         v  = (p / H_TOT) % V_TOT;
         pe = k - 1;
         he = pe % H_TOT;
         ve = (pe / H_TOT) % V_TOT;
         exp_de = (h < 640) && (v < V_ACTIVE);
`ifdef FB_SCANOUT_TEST_PATTERN_EN
         exp_rgb = exp_de ? int'(bars[h / 80]) : 0;
         exp_en  = 1'b0;
`else
         exp_rgb = exp_de ? (v / 2) * 320 + h / 2 : 0;
         exp_en  = (he < 640) && (ve < V_ACTIVE);
`endif
         if (p >= 5 && rgb !== 24'(exp_rgb)) mm_pat++;
         if (fb_en_rd !== exp_en) mm_pat++;
`ifdef FB_SCANOUT_TEST_PATTERN_EN
         if (p == 40) check("bar_white", rgb, 32'hFFFFFF);
         if (p == 100) check("bar_yellow", rgb, 32'hFFFF00);
         if (p == H_TOT + 250) check("bar_green", rgb, 32'h00FF00);
         if (p == 600) check("bar_black", rgb, 32'h000000);
`else
         if (p == 40) check("nopat_px40", rgb, 20);
         if (p == 100) check("nopat_px100", rgb, 50);
         if (p == H_TOT + 250) check("nopat_px_250_1", rgb, 125);
         if (p == 600) check("nopat_px600", rgb, 300);
`endif
      end
      check("mm_pattern", mm_pat, 0);
      pattern_sel = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
